// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store engine driving a req/ack data bus.
// Stalls the pipeline front while an access is in flight, aligns store data
// onto byte lanes, and extends load data for write-back.
// Optional feature macro: DMEM_TIMEOUT_EN (bus timeout with access-fault codes).

`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module mem_access_unit #(
  parameter int unsigned XLEN           = `XLEN_64b,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  localparam int unsigned W             = 1 << (XLEN + 4),
  localparam int unsigned NB            = W / 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [W-1:0]  i_alu_out_m,
  input  logic [W-1:0]  i_haz_b_m,
  input  logic          i_mem_write_m,
  input  logic [1:0]    i_result_src_m,
  input  logic [2:0]    i_f3_m,
  input  logic          i_store_byte_m,
  input  logic          i_store_half_m,
  output logic          o_stall_m,
  output logic          o_dmem_req,
  output logic          o_dmem_we,
  output logic [W-1:0]  o_dmem_addr,
  output logic [W-1:0]  o_dmem_wdata,
  output logic [NB-1:0] o_dmem_be,
  input  logic          i_dmem_ack,
  input  logic [W-1:0]  i_dmem_rdata,
  output logic [W-1:0]  o_load_data_m,
  output logic          o_load_valid_m,
  output logic [3:0]    o_exception_code_m
);

  localparam int unsigned OFFW = $clog2(NB);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t          state_q, state_d;

  logic            op_store, op_load, op_valid, misaligned;
  logic            latch_en, capture;
  logic [1:0]      size;
  logic [OFFW-1:0] off;
  logic [NB-1:0]   size_mask, be_c;
  logic [W-1:0]    wdata_c, lane, ext_c;

  logic [W-1:0]    addr_q, wdata_q;
  logic [NB-1:0]   be_q;
  logic            we_q, load_q;
  logic [2:0]      f3_q;
  logic [OFFW-1:0] off_q;
  logic [W-1:0]    load_data_q;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNTW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNTW-1:0] tmo_cnt_q;
  logic            tmo_q, tmo_d;
`endif

  // Decode the incoming op: kind, size, alignment, lane mask and shifted data.
  always_comb begin
    op_store = i_mem_write_m;
    op_load  = !i_mem_write_m && (i_result_src_m == 2'b01);
    op_valid = op_store || op_load;
    if (i_store_byte_m)      size = 2'd0;
    else if (i_store_half_m) size = 2'd1;
    else                     size = i_f3_m[1:0];
    if ((W == 32) && (size == 2'd3)) size = 2'd2;
    off = i_alu_out_m[OFFW-1:0];
    case (size)
      2'd0: begin misaligned = 1'b0;       size_mask = NB'(1'b1);   end
      2'd1: begin misaligned = off[0];     size_mask = NB'(2'b11);  end
      2'd2: begin misaligned = |off[1:0];  size_mask = NB'(4'hF);   end
      default: begin misaligned = |off;    size_mask = '1;          end
    endcase
    be_c    = NB'(size_mask << off);
    wdata_c = W'(i_haz_b_m << {off, 3'b000});
  end

  // Select the addressed lane of read data and extend it per funct3.
  always_comb begin
    lane = i_dmem_rdata >> {off_q, 3'b000};
    case (f3_q)
      3'b000:  ext_c = W'($signed(lane[7:0]));
      3'b001:  ext_c = W'($signed(lane[15:0]));
      3'b010:  ext_c = W'($signed(lane[31:0]));
      3'b100:  ext_c = W'(lane[7:0]);
      3'b101:  ext_c = W'(lane[15:0]);
      3'b110:  ext_c = W'(lane[31:0]);
      default: ext_c = lane;
    endcase
  end

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic plus stall, exception and latch/capture strobes.
  always_comb begin
    state_d            = state_q;
    o_stall_m          = 1'b0;
    o_exception_code_m = 4'hF;
    latch_en           = 1'b0;
    capture            = 1'b0;
`ifdef DMEM_TIMEOUT_EN
    tmo_d              = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (misaligned) begin
            o_exception_code_m = op_store ? 4'd6 : 4'd4;
          end else begin
            o_stall_m = 1'b1;
            latch_en  = 1'b1;
            state_d   = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        o_stall_m = 1'b1;
        if (i_dmem_ack) begin
          capture = load_q;
          state_d = S_DONE;
        end
`ifdef DMEM_TIMEOUT_EN
        else if (tmo_cnt_q == CNTW'(TIMEOUT_CYCLES - 1)) begin
          tmo_d   = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_DONE: begin
        state_d = S_IDLE;
`ifdef DMEM_TIMEOUT_EN
        if (tmo_q) o_exception_code_m = load_q ? 4'd5 : 4'd7;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Latch the bus transaction when an aligned op is accepted.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      load_q  <= 1'b0;
      f3_q    <= 3'b000;
      off_q   <= '0;
    end else if (latch_en) begin
      addr_q  <= {i_alu_out_m[W-1:OFFW], OFFW'(0)};
      wdata_q <= wdata_c;
      be_q    <= be_c;
      we_q    <= op_store;
      load_q  <= op_load;
      f3_q    <= i_f3_m;
      off_q   <= off;
    end
  end

  // Load result register; holds until the next acknowledged load.
  always_ff @(posedge i_clk) begin
    if (i_rst)        load_data_q <= '0;
    else if (capture) load_data_q <= ext_c;
  end

`ifdef DMEM_TIMEOUT_EN
  // Wait-cycle counter and timeout flag for the DONE cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      if (latch_en)
        tmo_cnt_q <= '0;
      else if ((state_q == S_ACCESS) && !i_dmem_ack)
        tmo_cnt_q <= tmo_cnt_q + CNTW'(1);
    end
  end

  assign o_load_valid_m = (state_q == S_DONE) && load_q && !tmo_q;
`else
  assign o_load_valid_m = (state_q == S_DONE) && load_q;
`endif

  assign o_dmem_req    = (state_q == S_ACCESS);
  assign o_dmem_we     = we_q;
  assign o_dmem_addr   = addr_q;
  assign o_dmem_wdata  = wdata_q;
  assign o_dmem_be     = be_q;
  assign o_load_data_m = load_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (64-bit datapath): directed table,
// multi-cycle reset/timeout sequences, and randomized ops against a model.
module tb_mem_access_unit;

  logic        clk, rst;
  logic [63:0] alu_out, haz_b;
  logic        mem_write;
  logic [1:0]  result_src;
  logic [2:0]  f3;
  logic        store_byte, store_half;
  logic        stall, dmem_req, dmem_we;
  logic [63:0] dmem_addr, dmem_wdata;
  logic [7:0]  dmem_be;
  logic        dmem_ack;
  logic [63:0] dmem_rdata, load_data;
  logic        load_valid;
  logic [3:0]  exc_code;

  int checks = 0;
  int failures = 0;
  logic [63:0] last_load = 64'd0;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_alu_out_m(alu_out), .i_haz_b_m(haz_b),
    .i_mem_write_m(mem_write), .i_result_src_m(result_src), .i_f3_m(f3),
    .i_store_byte_m(store_byte), .i_store_half_m(store_half),
    .o_stall_m(stall), .o_dmem_req(dmem_req), .o_dmem_we(dmem_we),
    .o_dmem_addr(dmem_addr), .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be),
    .i_dmem_ack(dmem_ack), .i_dmem_rdata(dmem_rdata),
    .o_load_data_m(load_data), .o_load_valid_m(load_valid),
    .o_exception_code_m(exc_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic        we;
    logic [1:0]  rsrc;
    logic [2:0]  f3;
    logic        sb;
    logic        sh;
    logic [63:0] rdata;
    int          delay;
    logic [3:0]  exp_exc;
    logic [63:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wdata;
    logic [63:0] exp_ldata;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [63:0] addr, input logic [63:0] data,
                              input logic we, input logic [1:0] rsrc, input logic [2:0] f,
                              input logic sb, input logic sh, input logic [63:0] rdata,
                              input int delay, input logic [3:0] exc, input logic [63:0] eaddr,
                              input logic [7:0] ebe, input logic [63:0] ewd,
                              input logic [63:0] eld);
    vec_t v;
    v.addr = addr; v.data = data; v.we = we; v.rsrc = rsrc; v.f3 = f;
    v.sb = sb; v.sh = sh; v.rdata = rdata; v.delay = delay;
    v.exp_exc = exc; v.exp_addr = eaddr; v.exp_be = ebe;
    v.exp_wdata = ewd; v.exp_ldata = eld;
    return v;
  endfunction

  // Behavioural model: expected bus fields and load result from access rules.
  function automatic vec_t ref_model(input vec_t v);
    vec_t r;
    int bytes, off, nb;
    logic [63:0] ln, mask, val;
    bit present;
    r = v;
    present = v.we || (v.rsrc == 2'b01);
    bytes = v.sb ? 1 : (v.sh ? 2 : (1 << v.f3[1:0]));
    off = int'(v.addr % 64'd8);
    r.exp_exc = 4'hF;
    if (present && ((v.addr % 64'(bytes)) != 64'd0)) r.exp_exc = v.we ? 4'd6 : 4'd4;
    r.exp_addr = v.addr - 64'(off);
    r.exp_be = 8'(((1 << bytes) - 1) << off);
    r.exp_wdata = v.data << (8 * off);
    ln = v.rdata >> (8 * off);
    if (v.f3[1:0] == 2'b11) begin
      val = ln;
    end else begin
      nb = 8 << v.f3[1:0];
      mask = (64'd1 << nb) - 64'd1;
      val = ln & mask;
      if (!v.f3[2] && ln[nb-1]) val = val | ~mask;
    end
    r.exp_ldata = val;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    alu_out = v.addr; haz_b = v.data; mem_write = v.we; result_src = v.rsrc;
    f3 = v.f3; store_byte = v.sb; store_half = v.sh;
  endtask

  task automatic clear_inputs();
    alu_out = '0; haz_b = '0; mem_write = 1'b0; result_src = 2'b00;
    f3 = 3'b000; store_byte = 1'b0; store_half = 1'b0;
  endtask

  // One complete op starting at the next edge; checks every cycle of it.
  task automatic do_op(input vec_t v, input string nm);
    bit present, is_load;
    int stalls;
    present = v.we || (v.rsrc == 2'b01);
    is_load = !v.we && (v.rsrc == 2'b01);
    stalls = 0;
    @(posedge clk); #1;
    drive(v); dmem_ack = 1'b0;
    #3;
    chk({nm, ".exc"}, 64'(exc_code), 64'(v.exp_exc));
    chk({nm, ".req0"}, 64'(dmem_req), 64'd0);
    if (!present || v.exp_exc != 4'hF) begin
      chk({nm, ".nostall"}, 64'(stall), 64'd0);
      return;
    end
    stalls += int'(stall);
    for (int k = 0; k <= v.delay; k++) begin
      @(posedge clk); #1;
      dmem_ack = (k == v.delay);
      dmem_rdata = v.rdata;
      #3;
      stalls += int'(stall);
      chk({nm, ".req"}, 64'(dmem_req), 64'd1);
      chk({nm, ".we"}, 64'(dmem_we), 64'(v.we));
      chk({nm, ".addr"}, dmem_addr, v.exp_addr);
      chk({nm, ".be"}, 64'(dmem_be), 64'(v.exp_be));
      if (v.we) chk({nm, ".wdata"}, dmem_wdata, v.exp_wdata);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    dmem_rdata = {$urandom, $urandom};
    #3;
    stalls += int'(stall);
    chk({nm, ".done_req"}, 64'(dmem_req), 64'd0);
    chk({nm, ".valid"}, 64'(load_valid), 64'(is_load));
    chk({nm, ".done_exc"}, 64'(exc_code), 64'hF);
    if (is_load) last_load = v.exp_ldata;
    chk({nm, ".ldata"}, load_data, last_load);
    chk({nm, ".stalls"}, 64'(stalls), 64'(v.delay + 2));
  endtask

  vec_t tbl[12];
  vec_t v;

  initial begin
    rst = 1'b1; dmem_ack = 1'b0; dmem_rdata = '0;
    clear_inputs();

    // Reset values.
    @(posedge clk); @(posedge clk); #4;
    chk("rst.stall", 64'(stall), 64'd0);
    chk("rst.req", 64'(dmem_req), 64'd0);
    chk("rst.we", 64'(dmem_we), 64'd0);
    chk("rst.addr", dmem_addr, 64'd0);
    chk("rst.wdata", dmem_wdata, 64'd0);
    chk("rst.be", 64'(dmem_be), 64'd0);
    chk("rst.ldata", load_data, 64'd0);
    chk("rst.valid", 64'(load_valid), 64'd0);
    chk("rst.exc", 64'(exc_code), 64'hF);
    @(posedge clk); #1; rst = 1'b0;

    // addr, data, we, rsrc, f3, sb, sh, rdata, delay, exc, eaddr, ebe, ewdata, eldata
    tbl[0]  = mk(64'h1003, 0, 0, 2'b01, 3'b000, 0, 0, 64'h00000000_80000000, 0,
                 4'hF, 64'h1000, 8'h08, 0, 64'hFFFFFFFF_FFFFFF80);
    tbl[1]  = mk(64'h2006, 64'hBEEF, 1, 2'b00, 3'b001, 0, 1, 0, 3,
                 4'hF, 64'h2000, 8'hC0, 64'hBEEF0000_00000000, 0);
    tbl[2]  = mk(64'h3002, 0, 0, 2'b01, 3'b010, 0, 0, 0, 0, 4'd4, 0, 0, 0, 0);
    tbl[3]  = mk(64'h4004, 0, 0, 2'b01, 3'b110, 0, 0, 64'h80000001_12345678, 0,
                 4'hF, 64'h4000, 8'hF0, 0, 64'h00000000_80000001);
    tbl[4]  = mk(64'h4008, 64'h01234567_89ABCDEF, 1, 2'b00, 3'b011, 0, 0, 0, 0,
                 4'hF, 64'h4008, 8'hFF, 64'h01234567_89ABCDEF, 0);
    tbl[5]  = mk(64'h5001, 64'h55, 1, 2'b00, 3'b010, 0, 0, 0, 0, 4'd6, 0, 0, 0, 0);
    tbl[6]  = mk(64'h6004, 0, 0, 2'b01, 3'b011, 0, 0, 0, 0, 4'd4, 0, 0, 0, 0);
    tbl[7]  = mk(64'h7002, 0, 0, 2'b01, 3'b001, 0, 0, 64'h00000000_80010000, 1,
                 4'hF, 64'h7000, 8'h0C, 0, 64'hFFFFFFFF_FFFF8001);
    tbl[8]  = mk(64'h7007, 0, 0, 2'b01, 3'b100, 0, 0, 64'hA5000000_00000000, 2,
                 4'hF, 64'h7000, 8'h80, 0, 64'h00000000_000000A5);
    tbl[9]  = mk(64'h8004, 64'hDEADBEEF, 1, 2'b01, 3'b010, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF, 0,
                 4'hF, 64'h8000, 8'hF0, 64'hDEADBEEF_00000000, 0);
    tbl[10] = mk(64'h9005, 64'h00000011_223344AB, 1, 2'b00, 3'b010, 1, 0, 0, 1,
                 4'hF, 64'h9000, 8'h20, 64'h3344AB00_00000000, 0);
    tbl[11] = mk(64'hA000, 0, 0, 2'b01, 3'b011, 0, 0, 64'hFEDCBA98_76543210, 0,
                 4'hF, 64'hA000, 8'hFF, 0, 64'hFEDCBA98_76543210);
    for (int i = 0; i < 12; i++) do_op(tbl[i], $sformatf("tbl%0d", i));
    @(posedge clk); #1; clear_inputs();

    // Reset during the second ACCESS cycle with an in-flight and a late ack.
    v = mk(64'hB000, 0, 0, 2'b01, 3'b010, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
    @(posedge clk); #1; drive(v); #3;
    chk("rsq.stall", 64'(stall), 64'd1);
    @(posedge clk); #4;
    chk("rsq.req1", 64'(dmem_req), 64'd1);
    @(posedge clk); #1; rst = 1'b1; dmem_ack = 1'b1; dmem_rdata = 64'h1234; clear_inputs(); #3;
    chk("rsq.req2", 64'(dmem_req), 64'd1);
    @(posedge clk); #1; rst = 1'b0; #3;
    last_load = 64'd0;
    chk("rsq.req_after", 64'(dmem_req), 64'd0);
    chk("rsq.exc", 64'(exc_code), 64'hF);
    chk("rsq.stall_after", 64'(stall), 64'd0);
    chk("rsq.valid", 64'(load_valid), 64'd0);
    @(posedge clk); #1; dmem_ack = 1'b0; #3;
    chk("rsq.late_valid", 64'(load_valid), 64'd0);
    chk("rsq.late_ldata", load_data, last_load);
    chk("rsq.late_req", 64'(dmem_req), 64'd0);

`ifdef DMEM_TIMEOUT_EN
    // No ack: DONE after four ACCESS cycles with an access-fault code.
    for (int s = 0; s < 2; s++) begin
      v = mk(64'hC000, 64'h77, (s == 1), (s == 0) ? 2'b01 : 2'b00, 3'b010, 0, 0, 0, 0,
             4'hF, 0, 0, 0, 0);
      @(posedge clk); #1; drive(v); dmem_ack = 1'b0; #3;
      chk("tmo.stall", 64'(stall), 64'd1);
      for (int k = 0; k < 4; k++) begin
        @(posedge clk); #4;
        chk("tmo.req", 64'(dmem_req), 64'd1);
      end
      @(posedge clk); #4;
      chk("tmo.exc", 64'(exc_code), (s == 0) ? 64'd5 : 64'd7);
      chk("tmo.valid", 64'(load_valid), 64'd0);
      chk("tmo.ldata", load_data, last_load);
      chk("tmo.stall_done", 64'(stall), 64'd0);
      chk("tmo.req_done", 64'(dmem_req), 64'd0);
      @(posedge clk); #1; clear_inputs(); #3;
      chk("tmo.idle_exc", 64'(exc_code), 64'hF);
      chk("tmo.idle_req", 64'(dmem_req), 64'd0);
    end
`else
    // No ack: the access waits indefinitely.
    begin
      int bad;
      bad = 0;
      v = mk(64'hC000, 0, 0, 2'b01, 3'b010, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0);
      @(posedge clk); #1; drive(v); dmem_ack = 1'b0;
      for (int k = 0; k < 120; k++) begin
        @(posedge clk); #4;
        if (!(dmem_req && stall) || exc_code != 4'hF) bad++;
      end
      chk("hang.cycles_not_waiting", 64'(bad), 64'd0);
      @(posedge clk); #1; rst = 1'b1; clear_inputs();
      @(posedge clk); #1; rst = 1'b0; #3;
      last_load = 64'd0;
      chk("hang.req_after_rst", 64'(dmem_req), 64'd0);
    end
`endif

    // Randomized ops against the reference model.
    for (int n = 0; n < 200; n++) begin
      int kind, bytes;
      kind = $urandom_range(0, 7);
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.addr = {$urandom, $urandom};
      v.data = {$urandom, $urandom};
      v.rdata = {$urandom, $urandom};
      v.delay = $urandom_range(0, 2);
      if (kind <= 3) begin
        v.we = 1'b0; v.rsrc = 2'b01;
        v.f3 = 3'($urandom_range(0, 6));
        if (v.f3 == 3'b111) v.f3 = 3'b011;
      end else if (kind <= 6) begin
        v.we = 1'b1; v.rsrc = 2'($urandom_range(0, 3));
        v.f3 = 3'($urandom_range(0, 3));
        v.sb = ($urandom_range(0, 5) == 0);
        v.sh = ($urandom_range(0, 5) == 0);
      end else begin
        v.we = 1'b0; v.rsrc = 2'($urandom_range(2, 3));
        v.f3 = 3'($urandom_range(0, 7));
      end
      bytes = v.sb ? 1 : (v.sh ? 2 : (1 << v.f3[1:0]));
      if ($urandom_range(0, 3) != 0) v.addr = v.addr & ~64'(bytes - 1);
      v = ref_model(v);
      do_op(v, $sformatf("rnd%0d", n));
    end
    @(posedge clk); #1; clear_inputs();
    @(posedge clk); #4;
    chk("end.req", 64'(dmem_req), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory-stage load/store engine placed directly downstream of the EX/MEM pipeline register. It takes the registered address, store data and control, and runs a request/acknowledge transaction on the data-memory bus. While the access is in flight it stalls the front of the pipeline, then returns the load result aligned and extended for write-back. Misaligned accesses raise an exception instead of issuing a bus request.

## Interface
- XLEN, default `XLEN_64b: width selector; datapath width W = 1<<(XLEN+4) (32 or 64).
- TIMEOUT_CYCLES, default 255: bus timeout limit. Used only when DMEM_TIMEOUT_EN is defined.
- i_clk  in  1  single clock; all state changes on posedge.
- i_rst  in  1  reset, synchronous and active-high.
- i_alu_out_m  in  W  effective byte address.
- i_haz_b_m  in  W  store data, held in the low bits.
- i_mem_write_m  in  1  store request.
- i_result_src_m  in  2  value 2'b01 marks a load.
- i_f3_m  in  3  access size and signedness (funct3).
- i_store_byte_m, i_store_half_m  in  1 each  store size overrides.
- o_stall_m  out  1  freeze request for upstream registers (drives their clk_en low).
- o_dmem_req  out  1  bus request.
- o_dmem_we  out  1  write enable.
- o_dmem_addr  out  W  address aligned to W/8 (low bits zeroed).
- o_dmem_wdata  out  W  store data shifted onto the addressed byte lanes.
- o_dmem_be  out  W/8  byte enables.
- i_dmem_ack  in  1  bus completion.
- i_dmem_rdata  in  W  read data.
- o_load_data_m  out  W  extended load result.
- o_load_valid_m  out  1  load result valid.
- o_exception_code_m  out  4  4'b1111 = none; 4/6 = load/store misaligned; 5/7 = load/store access fault.

## Operation
- Memory op present: i_mem_write_m=1 or i_result_src_m=2'b01. If both are set, the store takes priority.
- Size is taken from store_byte, then store_half, then f3[1:0]: 00 B, 01 H, 10 W, 11 D. D is legal only when W=64; at W=32 it is treated as W.
- Misaligned: H with addr[0]=1; W with addr[1:0]≠0; D with addr[2:0]≠0.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE, aligned op present: o_stall_m=1; latch address, size, f3, we, wdata, be; go to ACCESS.
  - IDLE, misaligned op present: o_exception_code_m=4 (load) or 6 (store) combinationally; no stall; no request; stay in IDLE.
  - ACCESS: o_dmem_req=1; o_stall_m=1. On i_dmem_ack go to DONE; for loads, capture the extended rdata in the same edge.
  - DONE: o_stall_m=0; o_load_valid_m=1 for loads; go to IDLE unconditionally. The op still visible on the inputs this cycle is not re-issued.
- Byte-lane offset = addr[log2(W/8)-1:0].
- Byte enables = size mask shifted left by the offset.
- Write data = i_haz_b_m shifted left by 8×offset.
- Load extension:
  - f3 000/001/010 sign-extend B/H/W.
  - f3 100/101/110 zero-extend B/H/W.
  - f3 011 is a full D load.
- i_dmem_ack outside ACCESS is ignored.
- o_dmem_* outputs are driven from latched registers and are stable throughout ACCESS.

## Timing
- Reset values: state IDLE; o_stall_m=0, o_dmem_req=0, o_dmem_we=0, addr/wdata/be=0, o_load_data_m=0, o_load_valid_m=0, o_exception_code_m=4'b1111, timeout counter=0.
- i_rst asserted in any state returns to IDLE on the next edge and drops o_dmem_req. An in-flight ack is discarded.
- Minimum access with ack in the first ACCESS cycle:
  - cycle 0: IDLE, stall=1.
  - cycle 1: ACCESS, req=1.
  - cycle 2: DONE, data valid, stall=0.
  - Cost: 2 stall cycles. Each extra wait cycle adds one stall cycle.
- o_load_data_m holds its last value until the next captured load.
- Back-to-back memory ops: the second op enters IDLE on the cycle after DONE.

## Configuration
- DMEM_TIMEOUT_EN defined:
  - An 8+-bit counter clears on entry to ACCESS and increments each ACCESS cycle without ack.
  - When the counter reaches TIMEOUT_CYCLES, the FSM goes to DONE with o_exception_code_m=5 (load) or 7 (store) for that DONE cycle.
  - o_load_valid_m=0 in that cycle; o_load_data_m is unchanged.
- DMEM_TIMEOUT_EN undefined: no counter; ACCESS waits indefinitely for ack, and codes 5 and 7 are never produced.

## Test plan
- W=64, LB at addr 0x1003 with rdata 0x00000000_80000000 → byte lane 3 = 0x80; be n/a; DONE shows o_load_data_m=0xFFFFFFFF_FFFFFF80, valid=1, 2 stall cycles with immediate ack.
- SH of 0xBEEF at addr 0x2006, ack delayed 3 cycles → be=8'b1100_0000, wdata[63:48]=0xBEEF, o_dmem_addr=0x2000, stall high for 5 cycles, we=1 throughout ACCESS.
- LW at addr 0x3002 → exception code 4 in the same cycle, o_dmem_req never asserted, o_stall_m=0.
- LWU at 0x4004 with rdata upper word 0x8000_0001 → 0x00000000_80000001. Then an immediate back-to-back SD at 0x4008 → second request begins the cycle after DONE; be=8'hFF.
- Reset asserted on the second ACCESS cycle → next edge IDLE, req=0, exception code 4'b1111; a late ack has no effect.
- DMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, load with no ack → DONE after 4 ACCESS cycles with code 5, valid=0; undefined build → stall persists for 100+ cycles.
